gf2_xor_join: RTL
=================

GF2_XOR_JOIN -- requirements
Module: gf2_xor_join

Interface
REQ-001 WIDTH, 96, bit width of every data word; a GF(2) vector of three 32-bit lanes.
REQ-002 FRAME_LEN, 1, output words per codeword frame; legal range 1..1024.
REQ-003 i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset, sampled on rising i_clock.
REQ-005 i_a_data  input  WIDTH  stream A word; A is the E-product stream from the upstream sparse multiply.
REQ-006 i_a_valid  input  1  stream A word present.
REQ-007 o_a_ready  output  1  stream A word accepted this cycle when high with i_a_valid.
REQ-008 i_b_data  input  WIDTH  stream B word; B is the companion C-product stream.
REQ-009 i_b_valid  input  1  stream B word present.
REQ-010 o_b_ready  output  1  stream B word accepted this cycle when high with i_b_valid.
REQ-011 o_output_data  output  WIDTH  bitwise XOR of one A word and one B word.
REQ-012 o_output_valid  output  1  o_output_data is valid.
REQ-013 i_output_ready  input  1  downstream accepts the word when high with o_output_valid.
REQ-014 o_output_last  output  1  high on the final word of each FRAME_LEN-word frame.

Function
REQ-015 Join: o_a_ready SHALL equal (!full && i_b_valid), and o_b_ready SHALL equal (!full && i_a_valid); A and B SHALL therefore always transfer in the same cycle, never one alone.
REQ-016 Push: a join (i_a_valid && i_b_valid && !full) SHALL write i_a_data ^ i_b_data into a 2-entry registered FIFO.
REQ-017 The output port SHALL drive the FIFO head directly; o_output_valid SHALL equal (count != 0).
REQ-018 Latency: a word joined in cycle N SHALL appear on o_output_valid in cycle N+1 if the FIFO was empty.
REQ-019 Pop: o_output_valid && i_output_ready SHALL remove the head entry.
REQ-020 full SHALL equal (count == 2), registered; ready SHALL never depend combinationally on i_output_ready.
REQ-021 Simultaneous push and pop with count==1 SHALL leave count at 1 and preserve order.
REQ-022 At count==2 with a pop, no push SHALL occur that cycle; ready rises the next cycle.
REQ-023 At count==0 there is no pop; o_output_data SHALL hold its previous value, which is don't-care.
REQ-024 Word order SHALL be strictly preserved; no word may be dropped or duplicated under any valid/ready pattern.
REQ-025 The output word counter SHALL increment on each pop and wrap from FRAME_LEN-1 to 0.
REQ-026 o_output_last SHALL equal o_output_valid && (counter == FRAME_LEN-1); with FRAME_LEN=1 it SHALL be high on every valid word.
REQ-027 Input data SHALL be ignored unless both valid signals are high; X on unused data SHALL not propagate.

Reset
REQ-028 While i_reset is high: count=0, counter=0, o_output_valid=0, o_output_last=0, o_a_ready=0, o_b_ready=0, o_output_data=0.
REQ-029 Reset asserted mid-frame or while the FIFO is full SHALL discard all stored words and restart the counter at 0 on the first cycle after release.
REQ-030 Joins SHALL be possible on the first cycle after reset deassertion.

Verification
REQ-031 No stimulus with i_output_ready=1 for 100 cycles -> zero output transfers; o_output_valid stays 0.
REQ-032 A valid with data 0x...0001_0000_0001 held and B valid=0 for 20 cycles -> o_a_ready=0 throughout, no output; then B=0x...0001_0000_0000 for one cycle -> exactly one output 0x0000_0000_0000_0000_0000_0001, with o_output_last=1 (FRAME_LEN=1).
REQ-033 i_output_ready=0 and 5 joins offered -> only 2 accepted, readies low from the 3rd cycle; then ready=1 -> 2 words out in order, then readies reassert.
REQ-034 FRAME_LEN=4, 12 back-to-back joins, A=k, B=0 for k=1..12 -> outputs 1..12 in order, o_output_last on words 4, 8 and 12.
REQ-035 Random valid/ready toggling with 1000 words, where A=random and B=A -> every output is 0, and the count equals 1000.
REQ-036 Reset pulse with 2 words stored and counter=2 (FRAME_LEN=4) -> no stored word emitted; the next 4 words end with o_output_last on the 4th.

Source files
------------

// File: rtl/gf2_xor_join.sv
// Joins two word streams into one by GF(2) addition (bitwise XOR), buffered by a 2-entry
// registered FIFO, and marks the last word of every FRAME_LEN-word frame.
module gf2_xor_join #(
  parameter int unsigned WIDTH     = 96,
  parameter int unsigned FRAME_LEN = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_a_data,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [WIDTH-1:0] i_b_data,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  output logic [WIDTH-1:0] o_output_data,
  output logic             o_output_valid,
  input  logic             i_output_ready,
  output logic             o_output_last
);

  localparam int unsigned    CntW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             full_q;
  logic [CntW-1:0]  frame_cnt_q;
  logic             push;
  logic             pop;

  // Readies depend only on registered fullness and the opposite valid, never on the sink.
  always_comb begin
    o_a_ready      = !i_reset && !full_q && i_b_valid;
    o_b_ready      = !i_reset && !full_q && i_a_valid;
    o_output_valid = !i_reset && (count_q != 2'd0);
    o_output_data  = i_reset ? '0 : mem_q[rd_ptr_q];
    o_output_last  = o_output_valid && (frame_cnt_q == LastIdx);
    push           = i_a_valid && o_a_ready;
    pop            = o_output_valid && i_output_ready;
    count_d        = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      full_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= i_a_data ^ i_b_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q    <= ~rd_ptr_q;
        frame_cnt_q <= (frame_cnt_q == LastIdx) ? '0 : frame_cnt_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == 2'd2);
    end
  end

endmodule
